cursor_update_scheduler: RTL and testbench

CURSOR_UPDATE_SCHEDULER -- requirements
Module: cursor_update_scheduler

---
 rtl/cursor_update_scheduler.sv | 127 ++++++++++++
 tb/tb_cursor_update_scheduler.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/cursor_update_scheduler.sv
// PS/2 make-code decoder feeding a small command FIFO; one queued cursor
// command is applied per frame strobe to the cursor position/colour registers.
//
// state   | meaning
// S_MAKE  | waiting for a make code or an F0 break prefix
// S_BREAK | F0 seen; the next valid byte is the released key and is dropped
module cursor_update_scheduler #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [9:0]  X_STEP     = 10'd32,
  parameter logic [9:0]  X_MAX      = 10'd96,
  parameter logic [9:0]  Y_MAX      = 10'd64
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iScanCode,
  input  logic       iScanValid,
  input  logic       iFrameStart,
  output logic [9:0] oXRedCounter,
  output logic [9:0] oYRedCounter,
  output logic [2:0] oColorCuadro,
  output logic [2:0] oPending,
  output logic       oOverflow
);

  localparam int unsigned AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [2:0]  FULL = 3'(FIFO_DEPTH);

  typedef enum logic {S_MAKE, S_BREAK} state_t;
  typedef enum logic [2:0] {CMD_LEFT, CMD_RIGHT, CMD_UP, CMD_DOWN, CMD_COLOR} cmd_t;

  state_t          r_state, w_state_next;
  cmd_t            w_cmd;
  logic            w_cmd_valid;
  cmd_t            r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [2:0]      r_count;
  logic [9:0]      r_x, r_y;
  logic [2:0]      r_color;
  logic            r_overflow;
  logic            w_pop, w_push, w_full;
  cmd_t            w_pop_cmd;

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_state <= S_MAKE;
    else       r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (iScanValid) begin
      case (r_state)
        S_MAKE:  if (iScanCode == 8'hF0) w_state_next = S_BREAK;
        S_BREAK: w_state_next = S_MAKE;
        default: w_state_next = S_MAKE;
      endcase
    end
  end

  // Output logic: command decode, only in S_MAKE (E0 simply falls to default)
  always_comb begin
    w_cmd_valid = 1'b0;
    w_cmd       = CMD_LEFT;
    if (iScanValid && r_state == S_MAKE) begin
      case (iScanCode)
        8'h6B:   begin w_cmd_valid = 1'b1; w_cmd = CMD_LEFT;  end
        8'h74:   begin w_cmd_valid = 1'b1; w_cmd = CMD_RIGHT; end
        8'h75:   begin w_cmd_valid = 1'b1; w_cmd = CMD_UP;    end
        8'h72:   begin w_cmd_valid = 1'b1; w_cmd = CMD_DOWN;  end
        8'h29:   begin w_cmd_valid = 1'b1; w_cmd = CMD_COLOR; end
        default: begin w_cmd_valid = 1'b0; w_cmd = CMD_LEFT;  end
      endcase
    end
  end

  assign w_full    = (r_count == FULL);
  assign w_pop     = iFrameStart && (r_count != 3'd0);
  // A full FIFO still accepts a push when a pop frees the slot in the same edge.
  assign w_push    = w_cmd_valid && (!w_full || w_pop);
  // Read is taken from the stored entry, so an empty FIFO never bypasses.
  assign w_pop_cmd = r_mem[r_rd_ptr];

  always_ff @(posedge Clock) begin
    if (w_push) r_mem[r_wr_ptr] <= w_cmd;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= 3'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 3'd1;
      else if (w_pop && !w_push) r_count <= r_count - 3'd1;
      if (w_cmd_valid && !w_push) r_overflow <= 1'b1;
    end
  end

  // Saturating moves compare against the headroom so no sum can wrap.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_x     <= 10'd0;
      r_y     <= 10'd0;
      r_color <= 3'b001;
    end else if (w_pop) begin
      case (w_pop_cmd)
        CMD_LEFT:  r_x <= (r_x >= X_STEP) ? r_x - X_STEP : 10'd0;
        CMD_RIGHT: r_x <= (X_MAX - r_x >= X_STEP) ? r_x + X_STEP : X_MAX;
        CMD_UP:    r_y <= (r_y >= X_STEP) ? r_y - X_STEP : 10'd0;
        CMD_DOWN:  r_y <= (Y_MAX - r_y >= X_STEP) ? r_y + X_STEP : Y_MAX;
        CMD_COLOR: r_color <= r_color + 3'd1;
        default:   r_color <= r_color;
      endcase
    end
  end

  assign oXRedCounter = r_x;
  assign oYRedCounter = r_y;
  assign oColorCuadro = r_color;
  assign oPending     = r_count;
  assign oOverflow    = r_overflow;

endmodule

// File: tb/tb_cursor_update_scheduler.sv
// Directed bench for cursor_update_scheduler; expected values are hand-computed
// from the default parameters (step 32, X max 96, Y max 64, depth 4).
module tb_cursor_update_scheduler;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] iScanCode = 8'h00;
  logic       iScanValid = 1'b0;
  logic       iFrameStart = 1'b0;
  logic [9:0] oXRedCounter, oYRedCounter;
  logic [2:0] oColorCuadro, oPending;
  logic       oOverflow;

  int total = 0;
  int bad   = 0;

  cursor_update_scheduler dut (
    .Clock(Clock), .Reset(Reset), .iScanCode(iScanCode), .iScanValid(iScanValid),
    .iFrameStart(iFrameStart), .oXRedCounter(oXRedCounter), .oYRedCounter(oYRedCounter),
    .oColorCuadro(oColorCuadro), .oPending(oPending), .oOverflow(oOverflow)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive, let the edge sample, then return #1 after the edge.
  task automatic step(input logic [7:0] sc, input logic v, input logic f);
    iScanCode = sc; iScanValid = v; iFrameStart = f;
    @(posedge Clock); #1;
    iScanValid = 1'b0; iFrameStart = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_x"},   16'(oXRedCounter), 16'd0);
    chk({tag, "_y"},   16'(oYRedCounter), 16'd0);
    chk({tag, "_col"}, 16'(oColorCuadro), 16'd1);
    chk({tag, "_pen"}, 16'(oPending),     16'd0);
    chk({tag, "_ovf"}, 16'(oOverflow),    16'd0);
  endtask

  initial begin
    logic [9:0] xexp [4];
    logic [9:0] yexp [4];
    logic [2:0] cexp [8];
    xexp[0] = 10'd32; xexp[1] = 10'd64; xexp[2] = 10'd96; xexp[3] = 10'd96;
    yexp[0] = 10'd0;  yexp[1] = 10'd32; yexp[2] = 10'd64; yexp[3] = 10'd64;
    cexp[0] = 3'd2; cexp[1] = 3'd3; cexp[2] = 3'd4; cexp[3] = 3'd5;
    cexp[4] = 3'd5; cexp[5] = 3'd5; cexp[6] = 3'd5; cexp[7] = 3'd5;

    repeat (2) @(posedge Clock);
    #1;
    chk_reset_vals("rst");
    step(8'h74, 1'b1, 1'b1);
    chk("rst_strobe_ignored", 16'(oPending), 16'd0);
    Reset = 1'b0;

    // Four RIGHTs, saturating at X_MAX
    for (int i = 0; i < 4; i++) step(8'h74, 1'b1, 1'b0);
    chk("r4_pend", 16'(oPending), 16'd4);
    for (int i = 0; i < 4; i++) begin
      step(8'h00, 1'b0, 1'b1);
      chk($sformatf("r4_x%0d", i), 16'(oXRedCounter), 16'(xexp[i]));
      chk($sformatf("r4_p%0d", i), 16'(oPending), 16'(3 - i));
    end
    step(8'h00, 1'b0, 1'b1);
    chk("empty_frame_x", 16'(oXRedCounter), 16'd96);
    chk("empty_frame_p", 16'(oPending), 16'd0);

    // Break sequence drops the released key
    do_reset();
    step(8'h74, 1'b1, 1'b0); step(8'hF0, 1'b1, 1'b0);
    step(8'h74, 1'b1, 1'b0); step(8'h6B, 1'b1, 1'b0);
    chk("brk_pend", 16'(oPending), 16'd2);
    step(8'h00, 1'b0, 1'b1);
    chk("brk_x1", 16'(oXRedCounter), 16'd32);
    step(8'h00, 1'b0, 1'b1);
    chk("brk_x2", 16'(oXRedCounter), 16'd0);

    // Six COLORs: two dropped, colour wraps modulo 8 otherwise
    do_reset();
    for (int i = 0; i < 6; i++) step(8'h29, 1'b1, 1'b0);
    chk("col_pend", 16'(oPending), 16'd4);
    chk("col_ovf", 16'(oOverflow), 16'd1);
    for (int i = 0; i < 8; i++) begin
      step(8'h00, 1'b0, 1'b1);
      chk($sformatf("col_c%0d", i), 16'(oColorCuadro), 16'(cexp[i]));
    end
    chk("col_pend_end", 16'(oPending), 16'd0);
    chk("col_ovf_sticky", 16'(oOverflow), 16'd1);

    // Full FIFO: push and pop on the same edge
    do_reset();
    step(8'h74, 1'b1, 1'b0); step(8'h74, 1'b1, 1'b0);
    step(8'h74, 1'b1, 1'b0); step(8'h29, 1'b1, 1'b0);
    step(8'h72, 1'b1, 1'b1);
    chk("full_x", 16'(oXRedCounter), 16'd32);
    chk("full_pend", 16'(oPending), 16'd4);
    chk("full_ovf", 16'(oOverflow), 16'd0);
    step(8'h00, 1'b0, 1'b1); chk("full_d1_x", 16'(oXRedCounter), 16'd64);
    step(8'h00, 1'b0, 1'b1); chk("full_d2_x", 16'(oXRedCounter), 16'd96);
    step(8'h00, 1'b0, 1'b1); chk("full_d3_c", 16'(oColorCuadro), 16'd2);
    step(8'h00, 1'b0, 1'b1); chk("full_d4_y", 16'(oYRedCounter), 16'd32);
    chk("full_d4_p", 16'(oPending), 16'd0);

    // UP at 0, then DOWN saturating at Y_MAX
    do_reset();
    step(8'h75, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(8'h72, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(8'h00, 1'b0, 1'b1);
      chk($sformatf("ud_y%0d", i), 16'(oYRedCounter), 16'(yexp[i]));
    end

    // E0 prefix ignored; push into empty FIFO with a frame strobe does not bypass
    do_reset();
    step(8'hE0, 1'b1, 1'b0); step(8'h6B, 1'b1, 1'b0);
    chk("e0_pend", 16'(oPending), 16'd1);
    step(8'h00, 1'b0, 1'b1);
    step(8'h74, 1'b1, 1'b1);
    chk("nobyp_x", 16'(oXRedCounter), 16'd0);
    chk("nobyp_p", 16'(oPending), 16'd1);
    step(8'h00, 1'b0, 1'b1);
    chk("nobyp_x2", 16'(oXRedCounter), 16'd32);

    // Mid-operation reset with queued commands and FSM in S_BREAK
    do_reset();
    step(8'h29, 1'b1, 1'b0); step(8'h74, 1'b1, 1'b0); step(8'h29, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b1);
    step(8'h74, 1'b1, 1'b0); step(8'hF0, 1'b1, 1'b0);
    chk("mid_pre_p", 16'(oPending), 16'd3);
    #2 Reset = 1'b1;
    #1 chk_reset_vals("mid");
    @(posedge Clock); #1;
    Reset = 1'b0;
    step(8'h29, 1'b1, 1'b0);
    chk("mid_post_p", 16'(oPending), 16'd1);
    step(8'h00, 1'b0, 1'b1);
    chk("mid_post_c", 16'(oColorCuadro), 16'd2);
    chk("mid_post_x", 16'(oXRedCounter), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
